// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks register-file addresses 0..N_REG-1 through one
// read port and streams (address, data) pairs over a valid/ready interface.
// Optional build macro: DUMP_SKIP_ZERO_EN (entries reading as zero are not
// presented; each skipped entry costs one cycle).
module regfile_dump_reader #(
    parameter int DATA_W = 16,
    parameter int N_REG  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        OUT,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_REG - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              skip_entry;

    // Zero entries are only dropped when the skip feature is built in.
`ifdef DUMP_SKIP_ZERO_EN
    assign skip_entry = (rf_rdata == '0);
`else
    assign skip_entry = 1'b0;
`endif

    // The walk pointer doubles as the registered read address.
    assign rf_raddr  = ptr_q;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state and output-register computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (skip_entry) begin
                    if (ptr_q == LAST_PTR) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end else begin
                    data_d  = rf_rdata;
                    addr_d  = ptr_q;
                    valid_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (ptr_q == LAST_PTR) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a scoreboard of expected entries.
// Honours DUMP_SKIP_ZERO_EN when the design is built with it.
module tb_regfile_dump_reader;

    localparam int DW = 16;
    localparam int NR = 32;
    localparam int AW = 5;
`ifdef DUMP_SKIP_ZERO_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic          out_valid, busy, done;
    logic [AW-1:0] rf_raddr, out_addr;
    logic [DW-1:0] rf_rdata, out_data;

    logic [DW-1:0] rf [NR];
    logic [AW+DW-1:0] sb [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    int c0 = 0;
    int hs0, d0;

    logic          stall_p = 1'b0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;

    regfile_dump_reader #(.DATA_W(DW), .N_REG(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Register file model: address sampled on the falling edge.
    always @(negedge clk) rf_rdata <= rf[rf_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: handshakes pop the scoreboard, stalls must hold stable.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_addr", 32'(out_addr), 32'(pa));
                chk("hold_data", 32'(out_data), 32'(pd));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_entry_addr", 32'(out_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("entry_addr", 32'(out_addr), 32'(e[AW+DW-1:DW]));
                    chk("entry_data", 32'(out_data), 32'(e[DW-1:0]));
                end
                hs_count++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            stall_p = out_valid && !out_ready;
            pa = out_addr;
            pd = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        for (int k = 0; k < NR; k++) begin
            if (!(SKIP == 1 && rf[k] == '0)) sb.push_back({AW'(k), rf[k]});
        end
    endtask

    // After return, cyc == c0 at the acceptance edge.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int limit);
        int base;
        base = done_count;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done_count != base) break;
        end
        chk("done_seen", 32'(done_count - base), 32'd1);
        tick();
    endtask

    task automatic wait_entry(input int a, input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (out_valid && out_addr == AW'(a)) break;
        end
        chk("reach_entry_valid", 32'(out_valid), 32'd1);
        chk("reach_entry_addr", 32'(out_addr), 32'(a));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < NR; k++) rf[k] = DW'(k * 16'h0101);
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_raddr", 32'(rf_raddr), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Full dump, ready always high.
        hs0 = hs_count; d0 = done_count;
        out_ready = 1'b1;
        push_all();
        do_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(200);
        chk("full_hs_count", 32'(hs_count - hs0), 32'(NR - SKIP));
        chk("full_last_hs_cycle", 32'(last_hs_cyc - c0), 32'(2 * NR - 1 - SKIP));
        // done is high in the cycle following the last handshake edge.
        chk("full_done_cycle", 32'(done_cyc - c0), 32'(2 * NR - SKIP));
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        tick(); tick(); tick();
        chk("full_done_once", 32'(done_count - d0), 32'd1);
        chk("full_busy_end", 32'(busy), 32'd0);

        // Backpressure at entry 3.
        hs0 = hs_count;
        push_all();
        do_start();
        wait_entry(3, 40);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_data", 32'(out_data), 32'h0303);
        out_ready = 1'b1;
        wait_done(200);
        chk("bp_hs_count", 32'(hs_count - hs0), 32'(NR - SKIP));
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // start re-pulsed while busy.
        hs0 = hs_count; d0 = done_count;
        push_all();
        do_start();
        wait_entry(2, 40);
        start = 1'b1; tick(); start = 1'b0;
        wait_entry(10, 40);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(200);
        for (int i = 0; i < 6; i++) tick();
        chk("restart_hs_count", 32'(hs_count - hs0), 32'(NR - SKIP));
        chk("restart_done_once", 32'(done_count - d0), 32'd1);
        chk("restart_idle_busy", 32'(busy), 32'd0);

        // Reset during OUT of entry 7.
        push_all();
        do_start();
        wait_entry(7, 40);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_raddr", 32'(rf_raddr), 32'd0);
        rst = 1'b0;
        sb.delete();
        d0 = done_count; hs0 = hs_count;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_done", 32'(done_count - d0), 32'd0);
        chk("abort_no_hs", 32'(hs_count - hs0), 32'd0);
        out_ready = 1'b1;
        push_all();
        do_start();
        wait_done(200);
        chk("abort_rerun_sb_empty", 32'(sb.size()), 32'd0);

        // Snapshot: write R4 while entry 4 is stalled.
        push_all();
        do_start();
        for (int i = 0; i < 40; i++) begin
            if (!out_valid && rf_raddr == AW'(4) && busy) break;
            tick();
        end
        chk("snap_rd4", 32'(rf_raddr), 32'd4);
        out_ready = 1'b0;
        tick();
        tick();
        rf[4] = 16'hAAAA;
        tick(); tick();
        chk("snap_old_value", 32'(out_data), 32'h0404);
        out_ready = 1'b1;
        wait_done(200);
        push_all();
        do_start();
        wait_done(200);
        chk("snap_sb_empty", 32'(sb.size()), 32'd0);

`ifdef DUMP_SKIP_ZERO_EN
        // Sparse file: only two nonzero registers.
        for (int k = 0; k < NR; k++) rf[k] = '0;
        rf[5] = 16'hBEEF;
        rf[31] = 16'h0001;
        hs0 = hs_count;
        push_all();
        do_start();
        wait_done(200);
        chk("skip_hs_count", 32'(hs_count - hs0), 32'd2);
        chk("skip_sb_empty", 32'(sb.size()), 32'd0);
        // All-zero file: no handshakes, done seen at edge N_REG+1.
        rf[5] = '0;
        rf[31] = '0;
        hs0 = hs_count;
        do_start();
        wait_done(200);
        chk("zero_hs_count", 32'(hs_count - hs0), 32'd0);
        chk("zero_done_cycle", 32'(done_cyc - c0), 32'(NR));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug read-out engine for the 32-entry CPU register file. On a start pulse it walks register addresses 0..N_REG-1 through one register-file read port. It streams each (address, data) pair out over a valid/ready interface to the simulation/debug host. It drives only the read side of the register file and never writes it.

Parameters:
DATA_W, 16, width of register data and of out_data
N_REG, 32, number of registers walked; must be 2..32
ADDR_W, 5, register address width; must satisfy N_REG <= 2**ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; one clock, reset is synchronous and active-high
start  in  1  dump request; sampled only in IDLE
rf_raddr  out  ADDR_W  read address to register file port
rf_rdata  in  DATA_W  read data from register file port
out_valid  out  1  out_addr/out_data hold a valid entry
out_ready  in  1  consumer accepts entry when out_valid && out_ready
out_addr  out  ADDR_W  register index of current entry
out_data  out  DATA_W  register contents of current entry
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last entry accepted

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; rf_raddr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0. Reset mid-dump aborts immediately. Remaining entries are not emitted and done does not pulse.
- RF read latency: rf_raddr is driven from a register at rising edge k. rf_rdata is valid and is sampled at rising edge k+1. The register file samples the address on the falling edge in between.
- FSM states:
  - IDLE: busy=0. start=1 -> ptr=0, rf_raddr=0, busy=1, go to RD.
  - RD: wait one cycle for read data. At the next edge, latch out_data=rf_rdata, out_addr=ptr, set out_valid=1, go to OUT.
  - OUT: hold out_addr/out_data/out_valid stable while out_ready=0. On handshake:
    - if ptr==N_REG-1: out_valid=0, go to FIN.
    - else: ptr+1, rf_raddr=ptr+1, out_valid=0, go to RD.
  - FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- Throughput: 2 cycles per entry with out_ready held high. A full 32-entry dump takes 64 cycles from start acceptance to the last handshake, and done follows 1 cycle later.
- out_valid never drops without a handshake, except on reset.
- start while busy: ignored, no restart, no queueing. start in the FIN cycle is also ignored.
- Back-to-back start: accepted again in IDLE the cycle after done.
- Data is a snapshot per entry, taken at its RD edge. Register writes made after that edge are not reflected in that entry.
- ptr never wraps; the walk stops at N_REG-1.

Optional Feature:
DUMP_SKIP_ZERO_EN
- Defined: at the RD->OUT decision, an entry with rf_rdata==0 is not presented; out_valid stays 0.
  - If ptr<N_REG-1, ptr advances and the FSM re-enters RD.
  - If ptr==N_REG-1, the FSM goes to FIN.
  - Skipped entries cost 1 cycle each.
  - All-zero file: no handshakes occur, and done pulses N_REG+1 cycles after start acceptance.
- Undefined: every register is emitted, including zeros.

Test Plan:
- Reset, then preload Rk=k*0x0101 and pulse start with out_ready=1 -> 32 handshakes, addresses 0..31, data 0x0000,0x0101,...,0x1F1F. done pulses once, on the cycle after the 32nd handshake, which falls 64 cycles after start.
- Backpressure: out_ready=0 for 5 cycles at entry 3 -> out_valid, out_addr=3 and out_data=0x0303 stay stable all 5 cycles. There are no duplicate or missing entries.
- start re-pulsed at entries 2 and 10 while busy -> ignored. The sequence is unchanged and there is a single done.
- rst asserted during OUT for entry 7 -> the next edge shows out_valid=0, busy=0, done=0 and the FSM in IDLE. A new start restarts at address 0.
- With DUMP_SKIP_ZERO_EN and only R5=0xBEEF and R31=0x0001 nonzero -> exactly 2 handshakes, (5,0xBEEF) then (31,0x0001), then done. With an all-zero file -> 0 handshakes and done 33 cycles after start.
- Snapshot: write R4=0xAAAA one cycle after the entry-4 RD edge while out_ready=0 -> entry 4 shows the old value. A second dump shows 0xAAAA.
